// File: rtl/avs_pkg.sv
// Shared defaults and helpers for the smoothed-value event path.
// Event words are packed MSB first as {value, delta, interval}.
package avs_pkg;

   localparam int BUS_DEFAULT   = 6;
   localparam int CNT_W_DEFAULT = 10;
   localparam int DEPTH_DEFAULT = 4;
   localparam int DROP_W        = 8;

   function automatic int event_width(input int b, input int c);
      return b + b + c;
   endfunction

   // Modular difference a-b kept to w bits; read as signed it is the circular delta.
   function automatic int unsigned circ_delta(input int unsigned a, input int unsigned b,
                                              input int w);
      int unsigned mask;
      if (w >= 32) mask = 32'hFFFF_FFFF;
      else         mask = (32'd1 << w) - 32'd1;
      return (a - b) & mask;
   endfunction

   function automatic int unsigned sat_inc(input int unsigned v, input int unsigned maxv);
      return (v >= maxv) ? maxv : v + 32'd1;
   endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with simultaneous push/pop; a push while full is accepted only
// when a pop frees the head slot in the same cycle.
module event_fifo #(
   parameter int WIDTH = 22,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/bearing_change_reporter.sv
// Turns the smoothed value stream into {value, delta, interval} change events,
// buffered for a valid/ready consumer with sticky drop accounting.
module bearing_change_reporter
   import avs_pkg::*;
#(
   parameter int bus   = BUS_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [bus-1:0]    datain,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [bus-1:0]    out_value,
   output logic [bus-1:0]    out_delta,
   output logic [CNT_W-1:0]  out_interval,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_count
);

   localparam int          EW      = event_width(bus, CNT_W);
   localparam int unsigned GAP_MAX = (32'd1 << CNT_W) - 32'd1;

   logic [bus-1:0]   last;
   logic [CNT_W-1:0] gap;
   logic [CNT_W-1:0] gap_inc;
   logic [bus-1:0]   delta;
   logic             chg;
   logic             pop;
   logic             push;
   logic             drop;
   logic             full;
   logic             empty;
   logic [EW-1:0]    wdata;
   logic [EW-1:0]    rdata;

   assign chg     = (datain != last);
   assign gap_inc = CNT_W'(sat_inc(32'(gap), GAP_MAX));
   assign delta   = bus'(circ_delta(32'(datain), 32'(last), bus));

   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   // A simultaneous pop makes room, so only a full FIFO without a pop loses the event.
   assign drop      = chg & full & ~pop;
   assign push      = chg & ~drop;
   assign wdata     = {datain, delta, gap_inc};

   assign {out_value, out_delta, out_interval} = rdata;

   event_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         last       <= '0;
         gap        <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (chg) begin
            last <= datain;
            gap  <= '0;
         end else begin
            gap <= gap_inc;
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != {DROP_W{1'b1}}) drop_count <= drop_count + {{(DROP_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_bearing_change_reporter.sv
// Directed bench: a queue scoreboard of expected events checked at every handshake,
// plus constant checks on drained events for the wrap, overflow and saturation cases.
module tb_bearing_change_reporter;

   localparam int BUS = 6;
   localparam int CW  = 10;
   localparam int DEP = 4;

   typedef struct {
      logic [BUS-1:0] value;
      logic [BUS-1:0] delta;
      logic [CW-1:0]  interval;
   } ev_t;

   logic           clock;
   logic           reset;
   logic [BUS-1:0] datain;
   logic           out_valid;
   logic           out_ready;
   logic [BUS-1:0] out_value;
   logic [BUS-1:0] out_delta;
   logic [CW-1:0]  out_interval;
   logic           overflow;
   logic [7:0]     drop_count;

   ev_t exp_q[$];
   ev_t popped[$];

   logic [BUS-1:0] m_last;
   int             m_gap;
   logic [7:0]     m_drops;
   logic           m_ovf;

   int n_asserts = 0;
   int n_fail    = 0;

   bearing_change_reporter #(.bus(BUS), .CNT_W(CW), .DEPTH(DEP)) dut (
      .clock        (clock),
      .reset        (reset),
      .datain       (datain),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_value    (out_value),
      .out_delta    (out_delta),
      .out_interval (out_interval),
      .overflow     (overflow),
      .drop_count   (drop_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      datain    = '0;
      out_ready = 1'b0;
      @(posedge clock);
      #1;
      reset   = 1'b0;
      exp_q.delete();
      m_last  = '0;
      m_gap   = 0;
      m_drops = '0;
      m_ovf   = 1'b0;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_value", 32'(out_value), 32'd0);
      chk("rst_delta", 32'(out_delta), 32'd0);
      chk("rst_interval", 32'(out_interval), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_drops", 32'(drop_count), 32'd0);
   endtask

   // One clock: drive, pop/compare at handshake, update model, then check state.
   task automatic tick(input logic [BUS-1:0] d, input logic rdy);
      ev_t e;
      ev_t p;
      bit  do_pop;
      bit  is_full;
      datain    = d;
      out_ready = rdy;
      #1;
      is_full = (exp_q.size() == DEP);
      do_pop  = (exp_q.size() > 0) && rdy;
      if (do_pop) begin
         chk("pop_valid", 32'(out_valid), 32'd1);
         chk("pop_value", 32'(out_value), 32'(exp_q[0].value));
         chk("pop_delta", 32'(out_delta), 32'(exp_q[0].delta));
         chk("pop_interval", 32'(out_interval), 32'(exp_q[0].interval));
         p.value    = out_value;
         p.delta    = out_delta;
         p.interval = out_interval;
         popped.push_back(p);
         void'(exp_q.pop_front());
      end
      if (d != m_last) begin
         e.value    = d;
         e.delta    = d - m_last;
         e.interval = CW'((m_gap + 1 > 1023) ? 1023 : m_gap + 1);
         m_last     = d;
         m_gap      = 0;
         if (is_full && !do_pop) begin
            m_ovf = 1'b1;
            if (m_drops != 8'hFF) m_drops = m_drops + 8'd1;
         end else begin
            exp_q.push_back(e);
         end
      end else begin
         m_gap = (m_gap + 1 > 1023) ? 1023 : m_gap + 1;
      end
      @(posedge clock);
      #1;
      chk("valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
      if (exp_q.size() != 0) begin
         chk("head_value", 32'(out_value), 32'(exp_q[0].value));
         chk("head_delta", 32'(out_delta), 32'(exp_q[0].delta));
         chk("head_interval", 32'(out_interval), 32'(exp_q[0].interval));
      end
   endtask

   initial begin
      reset     = 1'b1;
      datain    = '0;
      out_ready = 1'b0;

      do_reset();
      for (int i = 0; i < 20; i++) tick(6'd0, 1'b1);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_overflow", 32'(overflow), 32'd0);

      do_reset();
      popped.delete();
      for (int i = 1; i <= 9; i++) tick(6'd0, 1'b1);
      chk("pre_change_valid", 32'(out_valid), 32'd0);
      tick(6'd5, 1'b1);
      chk("latency1", 32'(out_valid), 32'd1);
      tick(6'd5, 1'b1);
      tick(6'd5, 1'b1);
      tick(6'd9, 1'b1);
      chk("latency2", 32'(out_valid), 32'd1);
      tick(6'd9, 1'b1);
      chk("ev_count", 32'(popped.size()), 32'd2);
      if (popped.size() == 2) begin
         chk("ev0_value", 32'(popped[0].value), 32'd5);
         chk("ev0_delta", 32'(popped[0].delta), 32'd5);
         chk("ev0_interval", 32'(popped[0].interval), 32'd10);
         chk("ev1_value", 32'(popped[1].value), 32'd9);
         chk("ev1_delta", 32'(popped[1].delta), 32'd4);
         chk("ev1_interval", 32'(popped[1].interval), 32'd3);
      end

      popped.delete();
      tick(6'd62, 1'b1);
      tick(6'd1, 1'b1);
      tick(6'd62, 1'b1);
      tick(6'd0, 1'b1);
      tick(6'd32, 1'b1);
      tick(6'd32, 1'b1);
      tick(6'd32, 1'b1);
      chk("wrap_count", 32'(popped.size()), 32'd5);
      if (popped.size() == 5) begin
         chk("wrap_62_to_1", 32'(popped[1].delta), 32'd3);
         chk("wrap_1_to_62", 32'(popped[2].delta), 32'b111101);
         chk("half_0_to_32", 32'(popped[4].delta), 32'b100000);
      end

      popped.delete();
      for (int v = 10; v <= 15; v++) tick(6'(v), 1'b0);
      chk("ovf_valid", 32'(out_valid), 32'd1);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_drops", 32'(drop_count), 32'd2);
      for (int i = 0; i < 4; i++) tick(6'd15, 1'b1);
      tick(6'd20, 1'b1);
      tick(6'd20, 1'b1);
      chk("drain_count", 32'(popped.size()), 32'd5);
      if (popped.size() == 5) begin
         chk("drain0_delta", 32'(popped[0].delta), 32'd42);
         for (int i = 0; i < 4; i++) chk("drain_order", 32'(popped[i].value), 32'(10 + i));
         chk("succ_delta", 32'(popped[4].delta), 32'd5);
      end
      chk("ovf_sticky", 32'(overflow), 32'd1);

      popped.delete();
      for (int i = 0; i < 1100; i++) tick(6'd20, 1'b1);
      tick(6'd21, 1'b1);
      tick(6'd21, 1'b1);
      chk("sat_count", 32'(popped.size()), 32'd1);
      if (popped.size() == 1) chk("sat_interval", 32'(popped[0].interval), 32'd1023);

      for (int v = 30; v <= 33; v++) tick(6'(v), 1'b0);
      tick(6'd34, 1'b1);
      chk("fullpp_drops", 32'(drop_count), 32'd2);
      chk("fullpp_valid", 32'(out_valid), 32'd1);
      tick(6'd34, 1'b1);
      chk("queued3", 32'(exp_q.size()), 32'd3);
      do_reset();
      for (int i = 0; i < 3; i++) tick(6'd0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/bearing_change_reporter.md
# bearing_change_reporter

Consumes the debounced `bus`-bit value produced by the smoothing stage every clock and turns it into a stream of change events. Each event carries the new value, the signed circular delta from the previous value, and the number of cycles since the previous change. Events are buffered in a small FIFO and drained through a valid/ready handshake toward the host-side logger. Loss of events under back-pressure is flagged and counted, never silent.

## Interface
Parameters:
- `bus`, 6, data width of the smoothed value, treated as a circular quantity mod 2^bus
- `CNT_W`, 10, width of the interval counter
- `DEPTH`, 4, event FIFO depth (power of two, ≥2)

Ports:
- `clock`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `datain`  in  bus  smoothed value, sampled every cycle
- `out_valid`  out  1  FIFO head holds an event
- `out_ready`  in  1  consumer accepts head when high with `out_valid`
- `out_value`  out  bus  value after the change
- `out_delta`  out  bus  signed two's-complement circular delta
- `out_interval`  out  CNT_W  cycles since previous change, saturating
- `overflow`  out  1  sticky: at least one event dropped
- `drop_count`  out  8  saturating count of dropped events

## Operation
- Registers: `last` (bus), `gap` (CNT_W), FIFO storage, pointers, `overflow`, `drop_count`.
- Change detect: `chg = (datain != last)`, evaluated each cycle, combinational on `datain`.
- On `chg`: push {datain, datain−last mod 2^bus, sat(gap+1)}; `last <= datain`; `gap <= 0`.
- No `chg`: `gap <= sat(gap+1)`; saturation value 2^CNT_W−1.
- Delta: raw modular difference reinterpreted as signed; half-circle (e.g. 0→32 at bus=6) reports −32 (6'b100000).
- Pop when `out_valid & out_ready`.
- Full FIFO, push without pop: event dropped, `overflow <= 1`, `drop_count` +1 saturating at 255; `last`/`gap` still update as if pushed.
- Full FIFO, push with pop: both happen, no drop.
- Empty FIFO, push: stored; no bypass, `out_valid` rises next cycle.
- Output fields always reflect FIFO head storage; meaningful only with `out_valid`.

## Timing
- Reset: `last`=0, `gap`=0, FIFO empty, storage cleared, `out_valid`=0, all output fields 0, `overflow`=0, `drop_count`=0. Reset mid-stream discards queued events.
- After reset `last`=0 matches the smoother's reset output; no spurious event.
- Latency: `datain` change at edge N sampled → `out_valid` high after edge N (visible cycle N+1) when FIFO was empty.
- Throughput: one push and one pop per cycle.
- `out_valid` and head fields stable while `out_valid & !out_ready`.
- `overflow` and `drop_count` cleared only by `reset`.

## Structure
- Shared package/include `avs_pkg`: default `bus`, event field widths, event concatenation order {value, delta, interval}, delta/saturation helper functions.
- One sub-module: `event_fifo` (synchronous FIFO, width bus+bus+CNT_W, depth `DEPTH`, full/empty, simultaneous push/pop). Top holds detect, delta, gap counter, drop accounting.

## Test plan
- Reset, hold `datain`=0 for 20 cycles → `out_valid` never asserts, `overflow`=0.
- 0 held, then 5 at cycle 10, then 9 at cycle 13, `out_ready`=1 → events {5,+5,interval 10}, {9,+4,3}; `out_valid` one cycle after each change.
- Wrap: `last`=62 → 1 gives delta +3; 1 → 62 gives −3 (6'b111101); 0 → 32 gives −32.
- `out_ready`=0, change `datain` on 6 consecutive cycles (DEPTH=4) → 4 events held, `overflow`=1, `drop_count`=2; then `out_ready`=1 drains the 4 in order, last-drained value's successor delta computed from the real previous value.
- `datain` constant 1100 cycles after a change, then change → `out_interval`=1023 (saturated).
- Full FIFO with `out_ready`=1 and a change in same cycle → no drop, count stays; `reset` asserted with 3 queued events → `out_valid`=0 next cycle, counters 0.
